fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00: the PC value loaded on reset.
REQ-002 Parameter IMEM_TIMEOUT, default 15: the maximum number of wait cycles for imem_ack; legal range is 1..255.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fetch_req  input  1  fetch strobe from the controller (its IR-memory-read output).
REQ-006 pcwrite  input  1  PC write enable from the controller.
REQ-007 pc_select  input  1  PC source select from the controller: 1 = branch target.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  8  instruction memory address.
REQ-010 imem_ack  input  1  instruction memory data-valid.
REQ-011 imem_rdata  input  16  instruction word.
REQ-012 pc  output  8  current PC.
REQ-013 opcode  output  3  IR[15:13].
REQ-014 mode_flag  output  3  IR[12:10], the branch condition.
REQ-015 rd  output  3  IR[12:10].
REQ-016 rs  output  3  IR[9:7].
REQ-017 imm  output  8  IR[7:0].
REQ-018 fetch_busy  output  1  high while in state REQ.
REQ-019 fetch_done  output  1  single-cycle pulse when a fetch completes.
REQ-020 fetch_err  output  1  sticky flag set on imem timeout.

Function
REQ-021 The block SHALL implement an FSM with states IDLE and REQ.
REQ-022 IDLE with fetch_req=1: go to REQ next cycle, latch imem_addr<=pc, clear the wait counter.
REQ-023 REQ: imem_req=1 and imem_addr held stable until exit; fetch_req is ignored.
REQ-024 REQ with imem_ack=1: IR<=imem_rdata, PC<=PC+1 (mod 256, 8'hFF wraps to 8'h00), fetch_done=1 next cycle, return to IDLE.
REQ-025 Fetch latency SHALL be 1 cycle plus the memory wait: with ack in the first REQ cycle, IR and PC update 2 edges after fetch_req.
REQ-026 REQ without ack: the wait counter increments; when it reaches IMEM_TIMEOUT, set fetch_err, keep IR and PC unchanged, pulse fetch_done, return to IDLE.
REQ-027 pcwrite=1 and pc_select=1 in IDLE: the next edge loads PC<=branch target.
REQ-028 pcwrite=1 and pc_select=0: ignored, because the increment is owned by this block.
REQ-029 pcwrite=1 and pc_select=1 in REQ: latch the target as a pending redirect.
REQ-030 At fetch completion (ack or timeout), a pending redirect SHALL override the increment: PC<=target and the pending flag is cleared.
REQ-031 fetch_req and redirect in the same IDLE cycle: PC<=target, imem_addr<=old PC, fetch proceeds.
REQ-032 The decode outputs SHALL be combinational slices of the IR; the IR changes only per REQ-024.

Reset
REQ-033 rst SHALL asynchronously force all of the following:
- state=IDLE; pc=RESET_PC; IR=16'h0000; imem_addr=8'h00;
- imem_req=0, fetch_busy=0, fetch_done=0, fetch_err=0;
- wait counter=0 and pending redirect cleared.
REQ-034 rst asserted during REQ SHALL abandon the transaction; a late imem_ack after release SHALL be ignored in IDLE.

Configuration
REQ-035 Macro FETCH_BRANCH_REL_EN defined: branch target = PC + sign-extended imm (8-bit wrap), where PC is the already-incremented value.
REQ-036 Macro FETCH_BRANCH_REL_EN undefined: branch target = imm (absolute).

Verification
REQ-037 Reset with RESET_PC=8'h00 -> pc=0x00, opcode=0, imem_req=0, fetch_err=0.
REQ-038 fetch_req, ack after 2 wait cycles with rdata=16'h8A85 -> opcode=3'b100, rd=3'b010, rs=3'b101, imm=8'h85, pc=0x01, one fetch_done pulse.
REQ-039 pc=0xFF, fetch with immediate ack -> pc=0x00.
REQ-040 No ack for 15 REQ cycles -> fetch_err=1, IR and pc unchanged, state IDLE; a later fetch with ack still works and fetch_err stays 1.
REQ-041 Redirect (imm=8'hFE) during REQ at pc=0x10, then ack -> pc=0x0F with FETCH_BRANCH_REL_EN, pc=0xFE without it.
REQ-042 rst pulse mid-REQ, then a late ack -> IR stays 16'h0000, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, IR and the imem request handshake with timeout.
// Optional macro FETCH_BRANCH_REL_EN selects PC-relative branch targets (default: absolute imm).
module fetch_unit #(
  parameter logic [7:0] RESET_PC     = 8'h00,
  parameter int         IMEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic        pcwrite,
  input  logic        pc_select,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [7:0]  pc,
  output logic [2:0]  opcode,
  output logic [2:0]  mode_flag,
  output logic [2:0]  rd,
  output logic [2:0]  rs,
  output logic [7:0]  imm,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        fetch_err
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  pend_tgt_q, pend_tgt_d;
  logic [15:0] ir_q, ir_d;
  logic        pend_q, pend_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        redirect_s;
  logic        take_redirect_s;
  logic [7:0]  target_s;
  logic [7:0]  redirect_pc_s;

  assign redirect_s = pcwrite & pc_select;

`ifdef FETCH_BRANCH_REL_EN
  // Base is the already-incremented PC: pc_q in IDLE, pc_q+1 while a fetch is in flight.
  // Sign-extending an 8-bit imm to 8 bits is the identity, so a plain wrapping add suffices.
  logic [7:0] base_s;
  assign base_s   = (state_q == REQ) ? (pc_q + 8'd1) : pc_q;
  assign target_s = base_s + ir_q[7:0];
`else
  assign target_s = ir_q[7:0];
`endif

  // A redirect in the completing cycle wins over an older pending one.
  assign take_redirect_s = pend_q | redirect_s;
  assign redirect_pc_s   = redirect_s ? target_s : pend_tgt_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    wait_d     = wait_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    ir_d       = ir_q;
    done_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (redirect_s) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
        if (fetch_req) begin
          state_d = REQ;
          addr_d  = pc_q;
          wait_d  = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (redirect_s) begin
          pend_d     = 1'b1;
          pend_tgt_d = target_s;
        end else begin
          pend_d     = pend_q;
        end
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = take_redirect_s ? redirect_pc_s : (pc_q + 8'd1);
          pend_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (wait_q == 8'(IMEM_TIMEOUT - 1)) begin
          pc_d    = take_redirect_s ? redirect_pc_s : pc_q;
          pend_d  = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= 8'h00;
      wait_q     <= 8'd0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 8'h00;
      ir_q       <= 16'h0000;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      wait_q     <= wait_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      ir_q       <= ir_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign imem_req   = (state_q == REQ);
  assign fetch_busy = (state_q == REQ);
  assign imem_addr  = addr_q;
  assign pc         = pc_q;
  assign fetch_done = done_q;
  assign fetch_err  = err_q;
  assign opcode     = ir_q[15:13];
  assign mode_flag  = ir_q[12:10];
  assign rd         = ir_q[12:10];
  assign rs         = ir_q[9:7];
  assign imm        = ir_q[7:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; honours FETCH_BRANCH_REL_EN like the design.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0, pcwrite = 1'b0, pc_select = 1'b0;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_req, fetch_busy, fetch_done, fetch_err;
  logic [7:0]  imem_addr, pc, imm;
  logic [2:0]  opcode, mode_flag, rd, rs;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_pc;
  logic [7:0] exp_tgt;

  fetch_unit #(.RESET_PC(8'h00), .IMEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pcwrite(pcwrite),
    .pc_select(pc_select), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .opcode(opcode),
    .mode_flag(mode_flag), .rd(rd), .rs(rs), .imm(imm),
    .fetch_busy(fetch_busy), .fetch_done(fetch_done), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch: strobe, `waits` ack-less REQ cycles, then an ack with `data`.
  task automatic fetch(input int waits, input logic [15:0] data, input logic [7:0] addr_exp);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("busy_in_req", {15'd0, fetch_busy}, 16'd1);
    check("imem_req", {15'd0, imem_req}, 16'd1);
    check("imem_addr", {8'd0, imem_addr}, {8'd0, addr_exp});
    for (int i = 0; i < waits; i++) begin
      tick();
      check("busy_wait", {15'd0, fetch_busy}, 16'd1);
      check("done_early", {15'd0, fetch_done}, 16'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    check("done_pulse", {15'd0, fetch_done}, 16'd1);
    check("busy_after", {15'd0, fetch_busy}, 16'd0);
    tick();
    check("done_cleared", {15'd0, fetch_done}, 16'd0);
  endtask

  task automatic redirect_idle();
    pcwrite   = 1'b1;
    pc_select = 1'b1;
    tick();
    pcwrite   = 1'b0;
    pc_select = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_pc", {8'd0, pc}, 16'h0000);
    check("rst_opcode", {13'd0, opcode}, 16'h0000);
    check("rst_imem_req", {15'd0, imem_req}, 16'd0);
    check("rst_err", {15'd0, fetch_err}, 16'd0);
    check("rst_busy_done", {14'd0, fetch_busy, fetch_done}, 16'd0);
    check("rst_addr", {8'd0, imem_addr}, 16'h0000);

    // pc_select=0 write is ignored.
    pcwrite = 1'b1;
    tick();
    pcwrite = 1'b0;
    check("pcwrite_sel0", {8'd0, pc}, 16'h0000);

    fetch(2, 16'h8A85, 8'h00);
    check("dec_opcode", {13'd0, opcode}, 16'h0004);
    check("dec_rd", {13'd0, rd}, 16'h0002);
    check("dec_mode", {13'd0, mode_flag}, 16'h0002);
    check("dec_rs", {13'd0, rs}, 16'h0005);
    check("dec_imm", {8'd0, imm}, 16'h0085);
    check("pc_after_fetch", {8'd0, pc}, 16'h0001);
    check("err_clear", {15'd0, fetch_err}, 16'd0);

    // Jump to 0xFF via an IDLE redirect.
`ifdef FETCH_BRANCH_REL_EN
    fetch(0, 16'h00FD, 8'h01);
`else
    fetch(0, 16'h00FF, 8'h01);
`endif
    check("pc_2", {8'd0, pc}, 16'h0002);
    redirect_idle();
    check("redir_idle_ff", {8'd0, pc}, 16'h00FF);

    fetch(0, 16'h000F, 8'hFF);
    check("pc_wrap", {8'd0, pc}, 16'h0000);
    redirect_idle();
    check("redir_idle_0f", {8'd0, pc}, 16'h000F);

    fetch(0, 16'h00FE, 8'h0F);
    check("pc_10", {8'd0, pc}, 16'h0010);

    // Redirect while in REQ, then ack.
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    pcwrite   = 1'b1;
    pc_select = 1'b1;
    tick();
    pcwrite   = 1'b0;
    pc_select = 1'b0;
    check("pc_held_req", {8'd0, pc}, 16'h0010);
    check("busy_pend", {15'd0, fetch_busy}, 16'd1);
    imem_ack   = 1'b1;
    imem_rdata = 16'h1234;
    tick();
    imem_ack   = 1'b0;
`ifdef FETCH_BRANCH_REL_EN
    exp_pc = 8'h0F;
`else
    exp_pc = 8'hFE;
`endif
    check("redir_req_pc", {8'd0, pc}, {8'd0, exp_pc});
    check("redir_req_imm", {8'd0, imm}, 16'h0034);
    tick();

    // Fetch strobe and redirect in the same IDLE cycle.
`ifdef FETCH_BRANCH_REL_EN
    exp_tgt = 8'h43;
`else
    exp_tgt = 8'h34;
`endif
    fetch_req = 1'b1;
    pcwrite   = 1'b1;
    pc_select = 1'b1;
    tick();
    fetch_req = 1'b0;
    pcwrite   = 1'b0;
    pc_select = 1'b0;
    check("same_cyc_addr", {8'd0, imem_addr}, {8'd0, exp_pc});
    check("same_cyc_pc", {8'd0, pc}, {8'd0, exp_tgt});
    imem_ack   = 1'b1;
    imem_rdata = 16'hE000;
    tick();
    imem_ack   = 1'b0;
    exp_pc = exp_tgt + 8'd1;
    check("same_cyc_done", {8'd0, pc}, {8'd0, exp_pc});
    check("opcode_7", {13'd0, opcode}, 16'h0007);
    tick();

    // Timeout: 15 REQ cycles with no ack.
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("to_busy_15th", {15'd0, fetch_busy}, 16'd1);
    check("to_no_err_yet", {15'd0, fetch_err}, 16'd0);
    tick();
    check("to_idle", {15'd0, fetch_busy}, 16'd0);
    check("to_err", {15'd0, fetch_err}, 16'd1);
    check("to_done", {15'd0, fetch_done}, 16'd1);
    check("to_pc", {8'd0, pc}, {8'd0, exp_pc});
    check("to_ir", {13'd0, opcode}, 16'h0007);
    tick();
    check("to_done_clr", {15'd0, fetch_done}, 16'd0);

    fetch(1, 16'h4C00, exp_pc);
    exp_pc = exp_pc + 8'd1;
    check("post_to_pc", {8'd0, pc}, {8'd0, exp_pc});
    check("post_to_opc", {13'd0, opcode}, 16'h0002);
    check("err_sticky", {15'd0, fetch_err}, 16'd1);

    // Reset mid-REQ, then a late ack.
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_req", {15'd0, imem_req}, 16'd0);
    check("async_pc", {8'd0, pc}, 16'h0000);
    check("async_err", {15'd0, fetch_err}, 16'd0);
    tick();
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 16'hFFFF;
    tick();
    imem_ack   = 1'b0;
    check("late_ack_ir", {opcode, rs, 2'b00, imm}, 16'h0000);
    check("late_ack_pc", {8'd0, pc}, 16'h0000);
    check("late_ack_idle", {14'd0, fetch_busy, fetch_done}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
